task_ring_dispatcher: RTL
=========================

# task_ring_dispatcher

Upstream stage of the virtualised PIFO ring: drains the per-port task FIFOs (show-ahead, one per ring slot) and injects push/pop operations into the LEVEL-slot RPU ring. Each tree's root lives in slot `tree_id % LEVEL`, and an injected op travels one slot per cycle. The block tracks ring occupancy itself, enforces a per-tree issue gap, splits combined push+pop tasks, and arbitrates per slot among the FIFOs.

## Interface
- PTW, 16, payload width
- MTW, 0, metadata width
- LEVEL, 4, ring slots / tree levels (power of 2)
- TREE_NUM, 4, virtual trees (power of 2, ≥ LEVEL)
- MIN_GAP, 2, minimum cycles between issues to the same tree (≥1)
- Derived: TNB = $clog2(TREE_NUM); TASK_W = PTW+MTW+2*TNB+2
- i_clk  in  1  clock
- i_arst  in  1  reset; one clock; reset is asynchronous and active-high
- i_fifo_empty  in  LEVEL  task FIFO f empty
- i_fifo_data[0:LEVEL-1]  in  TASK_W  FIFO f head, {push, pop, push_tree_id, pop_tree_id, data}
- o_pop_fifo  out  LEVEL  consume FIFO f head this cycle (combinational)
- o_rpu_push  out  LEVEL  inject push at slot s (registered)
- o_rpu_pop  out  LEVEL  inject pop at slot s (registered)
- o_rpu_tree_id[0:LEVEL-1]  out  TNB  tree of injected op
- o_rpu_push_data[0:LEVEL-1]  out  PTW+MTW  push payload; all-ones when not a push

## Operation
- Candidate op of FIFO f (non-empty):
  - pop bit set and split_pending[f]=0 → pop on pop_tree_id.
  - Otherwise, if the push bit is set → push on push_tree_id.
  - Target slot = tree_id[log2(LEVEL)-1:0].
- Entry with both bits set: the pop issues first, sets split_pending[f], and the head is NOT popped. The push issues later, then o_pop_fifo[f]=1 and split_pending[f] clears.
- Entry with neither bit set: popped immediately, no op issued, no arbitration slot consumed.
- Candidate is eligible when:
  - its target slot is free in the next output cycle, and
  - cooldown[tree]==0.
- Per slot, grant at most one eligible FIFO. Each FIFO issues at most one op per cycle.
- Occupancy: hops[s] (width $clog2(LEVEL)) = hops remaining for the op in slot s during the current output cycle.
  - Next cycle: hops_nxt[(s+1)%LEVEL] = hops[s]-1 if hops[s]>0.
  - Granted injection at slot s sets hops_nxt[s]=LEVEL-1.
  - Slot s is free iff hops[(s-1)%LEVEL] ≤ 1, i.e. no arriving traveller.
- Cooldown: on issue to tree t, cooldown[t] loads MIN_GAP-1; otherwise it decrements and saturates at 0.
- Non-granted FIFOs hold their head; there is no starvation within one slot under round-robin.

## Timing
- Reset values: o_rpu_push/o_rpu_pop = 0, o_rpu_tree_id = 0, o_rpu_push_data = all-ones, o_pop_fifo = 0.
- Internal state cleared at reset: hops, cooldown, split_pending, RR pointers.
- Reset asserted mid-operation discards all occupancy tracking; the ring must be reset together with this block.
- Latency: head valid at cycle t → op on o_rpu_* at t+1 (if granted at t). o_pop_fifo asserts in cycle t of the final op of the entry.
- Back-to-back FIFO throughput is 1 op/cycle/FIFO when slots are free and MIN_GAP=1.
- Tree id values ≥ TREE_NUM cannot occur (width-limited).

## Configuration
- TASK_RING_DISPATCHER_RR_EN defined: each slot uses a round-robin arbiter; the pointer advances to (grant+1) after each grant.
- Not defined: fixed priority, lowest FIFO index wins; no pointer state.

## Structure
- Package pifo_vtree_pkg holds:
  - TASK_W and TNB localparams
  - task_t packed struct {push, pop, push_tree_id, pop_tree_id, data}
  - root_slot() function
- Sub-module slot_rr_arbiter (LEVEL requests → one-hot grant, pointer register), instantiated once per slot.

## Test plan
- LEVEL=4, single pop task tree 2 in FIFO 0 → o_rpu_pop[2]=1, tree_id=2 next cycle; o_pop_fifo[0]=1 same cycle as the grant.
- Push on tree 1 injected at t → a push to tree 2 from another FIFO is blocked at t+1 (slot 2 occupied) and issues at t+2.
- Entry {push=1, pop=1, tree 3/3}, MIN_GAP=2 → pop at cycle t+1, push at t+3; o_pop_fifo pulses once, with the push.
- FIFOs 0–3 all targeting tree 0, RR_EN defined → grants 0,1,2,3 in order, subject to the gap and occupancy.
- Same setup without RR_EN → FIFO 0 drains fully before FIFO 1 is granted.
- Assert i_arst while ops are in flight → all outputs 0 / all-ones payload immediately; a task presented after release issues with no occupancy stall.

Source files
------------

// File: rtl/pifo_vtree_pkg.sv
// pifo_vtree_pkg: shared types and helpers for the virtualised PIFO ring.
// Holds default configuration, derived widths (TNB, TASK_W), the task entry
// layout task_t {push, pop, push_tree_id, pop_tree_id, data} and root_slot().
package pifo_vtree_pkg;
   localparam int DEF_PTW      = 16;
   localparam int DEF_MTW      = 0;
   localparam int DEF_LEVEL    = 4;
   localparam int DEF_TREE_NUM = 4;
   localparam int DEF_MIN_GAP  = 2;
   localparam int TNB          = $clog2(DEF_TREE_NUM);
   localparam int TASK_W       = DEF_PTW + DEF_MTW + 2 * TNB + 2;
   typedef struct packed {
      logic                       push;
      logic                       pop;
      logic [TNB-1:0]             push_tree_id;
      logic [TNB-1:0]             pop_tree_id;
      logic [DEF_PTW+DEF_MTW-1:0] data;
   } task_t;
   function automatic int unsigned root_slot(input int unsigned tree_id, input int unsigned level);
      return tree_id % level;
   endfunction
endpackage

// File: rtl/slot_rr_arbiter.sv
// slot_rr_arbiter: picks one requester per ring slot, one-hot grant.
// Ports: i_clk, i_arst (async, active-high), i_req[N] requests, o_gnt[N] one-hot grant.
// TASK_RING_DISPATCHER_RR_EN defined: round-robin, pointer moves to grant+1 after a grant.
// Otherwise: fixed priority, lowest index wins, no state.
module slot_rr_arbiter #(
   parameter int N = 4
)(
   input  logic         i_clk,
   input  logic         i_arst,
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_gnt
);
`ifdef TASK_RING_DISPATCHER_RR_EN
   localparam int PW = $clog2(N);
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_idx;
   logic [PW-1:0] w_win;
   logic          w_any;
   always_comb begin
      o_gnt = '0;
      w_any = 1'b0;
      w_win = r_ptr;
      w_idx = r_ptr;
      for (int i = 0; i < N; i++) begin
         w_idx = r_ptr + PW'(i);
         if (!w_any && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            w_any        = 1'b1;
            w_win        = w_idx;
         end
      end
   end
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) r_ptr <= '0;
      else if (w_any) r_ptr <= w_win + PW'(1);
   end
`else
   logic w_unused;
   logic w_any;
   assign w_unused = i_clk ^ i_arst;
   always_comb begin
      o_gnt = '0;
      w_any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!w_any && i_req[i]) begin
            o_gnt[i] = 1'b1;
            w_any    = 1'b1;
         end
      end
   end
`endif
endmodule

// File: rtl/task_ring_dispatcher.sv
// task_ring_dispatcher: drains per-slot show-ahead task FIFOs into the LEVEL-slot RPU ring.
// Ports: i_clk, i_arst (async, active-high); i_fifo_empty/i_fifo_data FIFO heads;
// o_pop_fifo (combinational head consume); o_rpu_push/o_rpu_pop/o_rpu_tree_id/
// o_rpu_push_data registered ring injections (payload all-ones when not a push).
// Optional: TASK_RING_DISPATCHER_RR_EN selects round-robin slot arbitration.
module task_ring_dispatcher
   import pifo_vtree_pkg::*;
#(
   parameter  int PTW      = DEF_PTW,
   parameter  int MTW      = DEF_MTW,
   parameter  int LEVEL    = DEF_LEVEL,
   parameter  int TREE_NUM = DEF_TREE_NUM,
   parameter  int MIN_GAP  = DEF_MIN_GAP,
   localparam int NB       = $clog2(TREE_NUM),
   localparam int DW       = PTW + MTW,
   localparam int TW       = DW + 2 * NB + 2
)(
   input  logic             i_clk,
   input  logic             i_arst,
   input  logic [LEVEL-1:0] i_fifo_empty,
   input  logic [TW-1:0]    i_fifo_data [LEVEL],
   output logic [LEVEL-1:0] o_pop_fifo,
   output logic [LEVEL-1:0] o_rpu_push,
   output logic [LEVEL-1:0] o_rpu_pop,
   output logic [NB-1:0]    o_rpu_tree_id [LEVEL],
   output logic [DW-1:0]    o_rpu_push_data [LEVEL]
);
   localparam int LB = $clog2(LEVEL);
   localparam int CW = $clog2(MIN_GAP) + 1;
   localparam logic [LB-1:0] HOP_LD = LB'(LEVEL - 1);
   localparam logic [CW-1:0] GAP_LD = CW'(MIN_GAP - 1);
   logic [LB-1:0]       r_hops [LEVEL];
   logic [CW-1:0]       r_cd [TREE_NUM];
   logic [LEVEL-1:0]    r_split;
   logic [LEVEL-1:0]    w_is_pop, w_op, w_none, w_elig, w_granted, w_free;
   logic [LEVEL-1:0]    w_inj_push, w_inj_pop;
   logic [NB-1:0]       w_tree [LEVEL];
   logic [LB-1:0]       w_slot [LEVEL];
   logic [LEVEL-1:0]    w_req [LEVEL];
   logic [LEVEL-1:0]    w_gnt [LEVEL];
   logic [NB-1:0]       w_inj_tree [LEVEL];
   logic [DW-1:0]       w_inj_data [LEVEL];
   logic [TREE_NUM-1:0] w_issue;

   // A slot is free next cycle unless a traveller with more than one hop left arrives from upstream.
   always_comb begin
      for (int s = 0; s < LEVEL; s++) w_free[s] = r_hops[(s + LEVEL - 1) % LEVEL] <= LB'(1);
      for (int f = 0; f < LEVEL; f++) begin
         w_is_pop[f] = i_fifo_data[f][TW-2] & ~r_split[f];
         w_op[f]     = ~i_fifo_empty[f] & (w_is_pop[f] | i_fifo_data[f][TW-1]);
         w_none[f]   = ~i_fifo_empty[f] & ~i_fifo_data[f][TW-1] & ~i_fifo_data[f][TW-2];
         w_tree[f]   = w_is_pop[f] ? i_fifo_data[f][DW +: NB] : i_fifo_data[f][DW + NB +: NB];
         w_slot[f]   = LB'(root_slot(32'(w_tree[f]), LEVEL));
         w_elig[f]   = w_op[f] & w_free[w_slot[f]] & (r_cd[w_tree[f]] == '0);
      end
   end

   always_comb begin
      for (int s = 0; s < LEVEL; s++)
         for (int f = 0; f < LEVEL; f++) w_req[s][f] = w_elig[f] & (w_slot[f] == LB'(s));
   end

   for (genvar g = 0; g < LEVEL; g++) begin : g_arb
      slot_rr_arbiter #(.N(LEVEL)) u_arb (
         .i_clk  (i_clk),
         .i_arst (i_arst),
         .i_req  (w_req[g]),
         .o_gnt  (w_gnt[g])
      );
   end

   always_comb begin
      w_granted  = '0;
      w_inj_push = '0;
      w_inj_pop  = '0;
      w_issue    = '0;
      for (int s = 0; s < LEVEL; s++) begin
         w_inj_tree[s] = '0;
         w_inj_data[s] = '1;
         for (int f = 0; f < LEVEL; f++) begin
            if (w_gnt[s][f]) begin
               w_granted[f]      = 1'b1;
               w_inj_push[s]     = ~w_is_pop[f];
               w_inj_pop[s]      = w_is_pop[f];
               w_inj_tree[s]     = w_tree[f];
               w_inj_data[s]     = w_is_pop[f] ? '1 : i_fifo_data[f][DW-1:0];
               w_issue[w_tree[f]] = 1'b1;
            end
         end
      end
   end

   // The head of a push+pop entry stays until its second (push) half issues.
   always_comb begin
      for (int f = 0; f < LEVEL; f++)
         o_pop_fifo[f] = ~i_arst & (w_none[f] | (w_granted[f] & ~(w_is_pop[f] & i_fifo_data[f][TW-1])));
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_split         <= '0;
         r_hops          <= '{default: '0};
         r_cd            <= '{default: '0};
         o_rpu_push      <= '0;
         o_rpu_pop       <= '0;
         o_rpu_tree_id   <= '{default: '0};
         o_rpu_push_data <= '{default: '1};
      end else begin
         for (int f = 0; f < LEVEL; f++)
            r_split[f] <= w_granted[f] ? (w_is_pop[f] & i_fifo_data[f][TW-1]) : r_split[f];
         for (int s = 0; s < LEVEL; s++)
            r_hops[s] <= (w_inj_push[s] | w_inj_pop[s]) ? HOP_LD :
                         (r_hops[(s + LEVEL - 1) % LEVEL] != '0 ? r_hops[(s + LEVEL - 1) % LEVEL] - LB'(1) : '0);
         for (int t = 0; t < TREE_NUM; t++)
            r_cd[t] <= w_issue[t] ? GAP_LD : (r_cd[t] != '0 ? r_cd[t] - CW'(1) : '0);
         o_rpu_push      <= w_inj_push;
         o_rpu_pop       <= w_inj_pop;
         o_rpu_tree_id   <= w_inj_tree;
         o_rpu_push_data <= w_inj_data;
      end
   end
endmodule
